// File: rtl/rx_char_restore.sv
// rx_char_restore
//
// Receive-side character restoration for a 4-octet JESD204 lane word.
// The block sits after 8b/10b decode and frame/multiframe alignment. It puts
// back the data octets that the transmitter replaced with /F/ (K28.7, 8'hFC)
// at frame ends and with /A/ (K28.3, 8'h7C) at multiframe ends. Octet 0 is
// the earliest octet in time.
//
// Replacement characters that sit in the wrong position are passed through
// unchanged, keep K=1, and are flagged per octet on ERR_F/ERR_A.
//
// Latency is a fixed 2 cycles:
//   stage 1 registers the inputs, the link qualifiers and the /F/ and /A/
//           decode;
//   stage 2 resolves the replacement chain against HIST and registers the
//           outputs.
//
// Ports
//   CLK    in   lane clock
//   RST_n  in   asynchronous active-low reset
//   EN     in   restoration enable (lane data phase); low = pass-through
//   SCR    in   scrambling enabled on the link
//   F      in   octets per frame minus 1
//   FE     in   [3:0] per-octet frame-end marker
//   ME     in   [3:0] per-octet multiframe-end marker
//   DI_K   in   [3:0] per-octet control flag
//   DI     in   [31:0] decoded octets, octet i at DI[8*i +: 8]
//   DO_K   out  [3:0] restored control flags
//   DO     out  [31:0] restored octets, octet i at DO[8*i +: 8]
//   ERR_F  out  [3:0] misplaced /F/ per octet
//   ERR_A  out  [3:0] misplaced /A/ per octet

module rx_char_restore (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        EN,
  input  logic        SCR,
  input  logic [7:0]  F,
  input  logic [3:0]  FE,
  input  logic [3:0]  ME,
  input  logic [3:0]  DI_K,
  input  logic [31:0] DI,
  output logic [3:0]  DO_K,
  output logic [31:0] DO,
  output logic [3:0]  ERR_F,
  output logic [3:0]  ERR_A
);

  localparam logic [7:0] CHAR_F = 8'hFC;
  localparam logic [7:0] CHAR_A = 8'h7C;

  // ---------------------------------------------------------------------------
  // Stage 1: input registers and character decode
  // ---------------------------------------------------------------------------

  // Replacement is only defined for frame sizes in which the transmitter
  // performs it. The qualifier is captured alongside the data it applies to.
  logic       sup_in;
  logic [3:0] isf_in;
  logic [3:0] isa_in;

  always_comb begin
    sup_in = EN & ((F == 8'd0) | (F == 8'd1) | ((F > 8'd2) & (F[1:0] == 2'b11)));
    isf_in = '0;
    isa_in = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      isf_in[i] = DI_K[i] & (DI[8*i +: 8] == CHAR_F);
      isa_in[i] = DI_K[i] & (DI[8*i +: 8] == CHAR_A);
    end
  end

  logic        s1_en;
  logic        s1_scr;
  logic        s1_sup;
  logic [3:0]  s1_fe;
  logic [3:0]  s1_me;
  logic [3:0]  s1_k;
  logic [31:0] s1_d;
  logic [3:0]  s1_isf;
  logic [3:0]  s1_isa;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      s1_en  <= 1'b0;
      s1_scr <= 1'b0;
      s1_sup <= 1'b0;
      s1_fe  <= '0;
      s1_me  <= '0;
      s1_k   <= '0;
      s1_d   <= '0;
      s1_isf <= '0;
      s1_isa <= '0;
    end else begin
      s1_en  <= EN;
      s1_scr <= SCR;
      s1_sup <= sup_in;
      s1_fe  <= FE;
      s1_me  <= ME;
      s1_k   <= DI_K;
      s1_d   <= DI;
      s1_isf <= isf_in;
      s1_isa <= isa_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: replacement chain, error flags, HIST
  // ---------------------------------------------------------------------------

  // Restored value of the most recent frame-end octet seen so far.
  logic [7:0]  hist;

  logic [31:0] do_nxt;
  logic [3:0]  dok_nxt;
  logic [3:0]  errf_nxt;
  logic [3:0]  erra_nxt;
  logic [7:0]  chain;
  logic [3:0]  fix;

  // The chain walks the octets in time order. After each frame-end octet it
  // holds that octet's restored value, so an unscrambled replacement copies
  // the nearest earlier frame end in this word, or HIST if there is none.
  // Back-to-back replaced frame ends (F=0) therefore all resolve to the same
  // value. Once the walk finishes, the chain is the next HIST.
  always_comb begin
    do_nxt   = s1_d;
    dok_nxt  = s1_k;
    errf_nxt = '0;
    erra_nxt = '0;
    fix      = '0;
    chain    = hist;
    for (int unsigned i = 0; i < 4; i++) begin
      fix[i] = s1_sup & ((s1_isf[i] & s1_fe[i] & ~s1_me[i]) |
                         (s1_isa[i] & s1_me[i]));
      if (fix[i]) begin
        dok_nxt[i] = 1'b0;
        if (s1_scr) begin
          do_nxt[8*i +: 8] = s1_isf[i] ? CHAR_F : CHAR_A;
        end else begin
          do_nxt[8*i +: 8] = chain;
        end
      end
      errf_nxt[i] = s1_sup & s1_isf[i] & ~(s1_fe[i] & ~s1_me[i]);
      erra_nxt[i] = s1_sup & s1_isa[i] & ~s1_me[i];
      if (s1_fe[i]) begin
        chain = do_nxt[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      DO    <= '0;
      DO_K  <= '0;
      ERR_F <= '0;
      ERR_A <= '0;
      hist  <= '0;
    end else begin
      DO    <= do_nxt;
      DO_K  <= dok_nxt;
      ERR_F <= errf_nxt;
      ERR_A <= erra_nxt;
      // HIST also tracks frame ends while the frame size is unsupported, and it
      // is emptied while the lane is out of the data phase.
      if (!s1_en) begin
        hist <= '0;
      end else if (|s1_fe) begin
        hist <= chain;
      end
    end
  end

endmodule

// File: doc/rx_char_restore.md
# rx_char_restore

Receive-side counterpart of the transmit character replacement stage in the JESD204 lane datapath. Sits after 8b/10b decode and frame/multiframe alignment, where FE/ME markers are already known. Restores control characters inserted by the transmitter at frame ends: /F/ (K28.7) and, at multiframe ends, /A/ (K28.3). Replacement characters in the wrong position are flagged per octet.

## Interface
Parameters: none; the lane word is fixed at 4 octets, and octet 0 is earliest in time.
- CLK  in  1  lane clock
- RST_n  in  1  reset; asynchronous, active-low
- EN  in  1  restoration enable (lane data phase); low = pure pass-through
- SCR  in  1  scrambling enabled on link
- F  in  8  octets per frame minus 1; restored only for F = 0, 1, or F+1 a multiple of 4
- FE  in  4  octet i is last octet of a frame
- ME  in  4  octet i is last octet of a multiframe (implies FE[i])
- DI_K  in  4  octet i is a control character
- DI  in  4x8  decoded octets
- DO_K  out  4  restored control flags
- DO  out  4x8  restored octets
- ERR_F  out  4  misplaced /F/ at octet i
- ERR_A  out  4  misplaced /A/ at octet i

## Operation
- Definitions:
  - isF[i] = DI_K[i] & DI[i]==8'hFC.
  - isA[i] = DI_K[i] & DI[i]==8'h7C.
  - supported = EN & (F==0 | F==1 | (F>2 & F[1:0]==2'b11)).
- Valid replacement at octet i, when supported:
  - (isF[i] & FE[i] & !ME[i]), or
  - (isA[i] & ME[i]).
- Restored value when SCR=1: data, fixed per character (no history):
  - /F/ → 8'hFC, K=0.
  - /A/ → 8'h7C, K=0.
- Restored value when SCR=0: data, K=0, equal to the restored value of the most recent earlier octet with FE set.
  - Search octets i-1 down to 0 in the current word.
  - If none is found, use register HIST.
  - The chain is evaluated in octet order within the word, so back-to-back replaced frame ends (F=0) all resolve to the same HIST-derived value.
- HIST (8 bits):
  - Updated when EN & |FE: takes the restored value of the highest-index FE octet.
  - Cleared to 8'h00 when EN=0.
  - Reset value 8'h00.
- Errors, asserted only when supported:
  - ERR_F[i] = isF[i] & !(FE[i] & !ME[i]).
  - ERR_A[i] = isA[i] & !ME[i].
  - Misplaced characters pass through unchanged, K=1.
- Non-replaced octets pass through with their DI_K.
- EN=0 or unsupported F: all octets pass through, ERR_F/ERR_A = 0, no replacement.

## Timing
- Fixed latency 2 cycles, DI to DO/DO_K/ERR_*:
  - Stage 1: registers inputs and the isF/isA decode.
  - Stage 2: resolves the replacement chain and registers outputs.
- HIST is read and written in stage 2. A frame end in word N feeds replacements in word N+1 with no bubble.
- EN, SCR and F are sampled in stage 1 together with the data they qualify.
- Reset (asynchronous, any time, including mid-frame):
  - DO = 0, DO_K = 0, ERR_F = 0, ERR_A = 0.
  - Stage registers = 0, HIST = 0.
  - The first two words after release produce zeros.
- EN fall: the pipeline keeps flushing. Words entered with EN=0 are pass-through, and HIST clears on the same edge the EN=0 word enters stage 2.
- The first frame end after EN rise replaces with 8'h00 when SCR=0 (HIST is empty); no error is raised.

## Test plan
- F=3, SCR=0, EN=1:
  - Word A: DI={8'h11,22,33,44}, FE=4'b1000.
  - Word B: DI[3]=FC, K[3]=1, FE=4'b1000.
  - Required: DO of B, 2 cycles later = {.., 8'h44}, DO_K=0, no error.
- F=0, SCR=0:
  - Previous FE octet restored = 8'h5A.
  - Word {FC,FC,7C,FC} with all FE set, K=4'hF, ME=4'b0100.
  - Required: DO = {5A,5A,5A,5A}, DO_K=0, ERR=0.
- F=1, SCR=1:
  - Word with DI[1]=FC/K, FE=4'b1010; DI[3]=7C/K, ME=4'b1000.
  - Required: DO[1]=FC with K=0, DO[3]=7C with K=0.
- Misplaced characters:
  - FC/K at octet 2 with FE[2]=0 → ERR_F=4'b0100, DO[2]=FC with K=1.
  - 7C/K at a frame end without ME → ERR_A set.
- EN=0, or F=2 with EN=1:
  - Stream of FC/K octets → identical output, K=1, errors 0, latency 2.
- Reset mid-stream:
  - Assert RST_n low asynchronously between clock edges → all outputs 0 immediately.
  - After release, the first frame-end /F/ (SCR=0) restores to 8'h00.
